// File: rtl/aes_mix_pkg.sv
// Shared constants and GF(2^8) helpers for the AES MixColumns datapath.
// Latency: none. This package holds only types and functions.
// Backpressure: not applicable.
package aes_mix_pkg;

    localparam logic [1:0] MIX_FWD = 2'b00;
    localparam logic [1:0] MIX_INV = 2'b01;
    localparam logic [1:0] MIX_BYP = 2'b10;
    localparam logic [1:0] MIX_RSV = 2'b11;

    // Products of one state byte that the S1 register stage holds: a, 2a, 4a and 8a.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
    } prod_t;

    // Multiplication by x (that is, by 2) modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic prod_t products(input logic [7:0] b);
        prod_t p;
        p.a  = b;
        p.x2 = xtime(b);
        p.x4 = xtime(p.x2);
        p.x8 = xtime(p.x4);
        return p;
    endfunction

    // The inverse-matrix coefficients decompose into sums of the x1/x2/x4/x8 terms.
    function automatic logic [7:0] gf_mul9(input prod_t p);
        return p.x8 ^ p.a;
    endfunction

    function automatic logic [7:0] gf_mul11(input prod_t p);
        return p.x8 ^ p.x2 ^ p.a;
    endfunction

    function automatic logic [7:0] gf_mul13(input prod_t p);
        return p.x8 ^ p.x4 ^ p.a;
    endfunction

    function automatic logic [7:0] gf_mul14(input prod_t p);
        return p.x8 ^ p.x4 ^ p.x2;
    endfunction

    // Mode 11 is always reserved. Mode 01 is also reserved when the inverse path is not built.
    function automatic logic is_reserved(input logic [1:0] mode, input bit inv_en);
        return (mode == MIX_RSV) || ((mode == MIX_INV) && !inv_en);
    endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational mixing of one 32-bit column from the precomputed byte products.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline registers the inputs and the output.
// Ports: p[r] = {a,2a,4a,8a} of row r; mode = 00 fwd / 01 inv / other bypass; col = mixed column, row 0 in bits [31:24].
module mix_col_word
    import aes_mix_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  prod_t [3:0]  p,
    input  logic  [1:0]  mode,
    output logic  [31:0] col
);

    always_comb begin
        col = '0;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] b;
            // Bypass is the fallback. This also covers the reserved encodings.
            b = p[r].a;
            if (mode == MIX_FWD) begin
                // 3a = 2a ^ a
                b = p[r].x2 ^ p[2'(r + 1)].x2 ^ p[2'(r + 1)].a
                  ^ p[2'(r + 2)].a ^ p[2'(r + 3)].a;
            end else if ((mode == MIX_INV) && INV_EN) begin
                b = gf_mul14(p[r]) ^ gf_mul11(p[2'(r + 1)])
                  ^ gf_mul13(p[2'(r + 2)]) ^ gf_mul9(p[2'(r + 3)]);
            end
            col[31 - 8*r -: 8] = b;
        end
    end

endmodule

// File: rtl/mix_columns_pipe.sv
// Pipelined AES MixColumns (forward / inverse / bypass) on NUM_COL columns per beat.
// Latency: 2 cycles. S1 holds the byte products and S2 holds the mixed result.
// Backpressure: valid/ready with full throughput; each stage loads when it is empty or when the stage after it is loading.
// Ports: in_valid/in_ready/in_mode/in_data give the input beat; out_valid/out_ready/out_data give the output beat;
//        err_mode is sticky and is set when a beat with a reserved mode is accepted.
module mix_columns_pipe
    import aes_mix_pkg::*;
#(
    parameter int NUM_COL = 4,
    parameter bit INV_EN  = 1'b1,
    localparam int W      = 32 * NUM_COL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         err_mode
);

    localparam int NBYTE = 4 * NUM_COL;

    prod_t [NBYTE-1:0] in_prod;
    prod_t [NBYTE-1:0] s1_prod;
    logic  [1:0]       s1_mode;
    logic              v1;
    logic              v2;
    logic              s1_load;
    logic              s2_load;
    logic              accept;
    logic  [W-1:0]     mixed;

    assign s2_load   = !v2 || out_ready;
    assign s1_load   = !v1 || s2_load;
    assign in_ready  = s1_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = v2;

    // The byte of column c, row r is stored at index 4*c+r.
    // Each column's four rows then form a contiguous slice for mix_col_word.
    always_comb begin
        in_prod = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            for (int r = 0; r < 4; r++) begin
                in_prod[4*c + r] = products(in_data[W - 1 - 32*c - 8*r -: 8]);
            end
        end
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        mix_col_word #(.INV_EN(INV_EN)) u_col (
            .p    (s1_prod[4*c +: 4]),
            .mode (s1_mode),
            .col  (mixed[W - 1 - 32*c -: 32])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_prod  <= '0;
            s1_mode  <= MIX_FWD;
            v2       <= 1'b0;
            out_data <= '0;
            err_mode <= 1'b0;
        end else begin
            if (s1_load) begin
                v1 <= accept;
                if (accept) begin
                    s1_prod <= in_prod;
                    s1_mode <= in_mode;
                end
            end
            // When S1 is empty, S2 drains to empty. out_data keeps its last value,
            // so a held output stays stable until it is taken.
            if (s2_load) begin
                v2 <= v1;
                if (v1) begin
                    out_data <= mixed;
                end
            end
            if (accept && is_reserved(in_mode, INV_EN)) begin
                err_mode <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_pipe.sv
module tb_mix_columns_pipe;
    import aes_mix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv;
    logic [1:0]   im;
    logic [255:0] id;
    logic         ordy;
    logic         ir4, ir8, irn;
    logic         ov4, ov8, ovn;
    logic         err4, err8, errn;
    logic [127:0] od4, odn;
    logic [255:0] od8;

    int total = 0;
    int bad   = 0;

    // Three DUTs share one stimulus stream: 4 columns, 8 columns, and 4 columns without the inverse path.
    mix_columns_pipe #(.NUM_COL(4), .INV_EN(1'b1)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir4), .in_mode(im),
        .in_data(id[255:128]), .out_valid(ov4), .out_ready(ordy), .out_data(od4), .err_mode(err4));
    mix_columns_pipe #(.NUM_COL(8), .INV_EN(1'b1)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir8), .in_mode(im),
        .in_data(id), .out_valid(ov8), .out_ready(ordy), .out_data(od8), .err_mode(err8));
    mix_columns_pipe #(.NUM_COL(4), .INV_EN(1'b0)) dn (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(irn), .in_mode(im),
        .in_data(id[255:128]), .out_valid(ovn), .out_ready(ordy), .out_data(odn), .err_mode(errn));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: generic shift-and-add GF multiply combined with the textbook matrices.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mcol(input logic [31:0] w, input logic [1:0] m, input bit inv_en);
        logic [7:0]  a [4];
        logic [7:0]  c [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = w[31 - 8*i -: 8];
        if (m == 2'b00) begin
            c[0] = 8'd2; c[1] = 8'd3; c[2] = 8'd1; c[3] = 8'd1;
        end else if (m == 2'b01 && inv_en) begin
            c[0] = 8'd14; c[1] = 8'd11; c[2] = 8'd13; c[3] = 8'd9;
        end else begin
            return w;
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = '0;
            for (int k = 0; k < 4; k++) b = b ^ gmul(c[k], a[(i + k) % 4]);
            r[31 - 8*i -: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [255:0] mstate(input logic [255:0] d, input logic [1:0] m, input bit inv_en);
        logic [255:0] r;
        for (int c = 0; c < 8; c++) r[255 - 32*c -: 32] = mcol(d[255 - 32*c -: 32], m, inv_en);
        return r;
    endfunction

    function automatic logic [127:0] colrev(input logic [127:0] d);
        return {d[31:0], d[63:32], d[95:64], d[127:96]};
    endfunction

    // Beat store plus an index scoreboard used by the streaming tests.
    localparam int NB = 1400;
    logic [1:0]   b_mode [NB];
    logic [255:0] b_data [NB];
    logic [255:0] b_e8   [NB];
    logic [127:0] b_en   [NB];
    int nb = 0;
    int sb[$];
    bit mon_en = 1'b0;

    task automatic add_beat(input logic [1:0] m, input logic [255:0] d);
        logic [255:0] t;
        b_mode[nb] = m;
        b_data[nb] = d;
        b_e8[nb]   = mstate(d, m, 1'b1);
        t          = mstate(d, m, 1'b0);
        b_en[nb]   = t[255:128];
        nb++;
    endtask

    always @(negedge clk) begin
        if (mon_en && ov4 && ordy) begin
            chk("sb_valid_agree", {ov8, ovn}, {ov4, ov4});
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got an output beat with an empty scoreboard, data %h", od8);
            end else begin
                int k;
                k = sb.pop_front();
                chk($sformatf("sb8[%0d]", k), od8, b_e8[k]);
                chk($sformatf("sb4[%0d]", k), {128'b0, od4}, {128'b0, b_e8[k][255:128]});
                chk($sformatf("sbn[%0d]", k), {128'b0, odn}, {128'b0, b_en[k]});
            end
        end
    end

    task automatic drain;
        int i;
        iv   = 1'b0;
        ordy = 1'b1;
        i    = 0;
        while (sb.size() > 0 && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        chk("drain_left", sb.size(), 0);
        chk("drain_idle", ov4, 0);
        mon_en = 1'b0;
    endtask

    task automatic run_stream(input int first, input int n, input int vpct, input int rpct);
        int idx;
        int cyc;
        bit acc;
        idx    = first;
        cyc    = 0;
        mon_en = 1'b1;
        while (idx < first + n && cyc < 20000) begin
            iv   = ($urandom_range(0, 99) < vpct);
            im   = b_mode[idx];
            id   = b_data[idx];
            ordy = ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            acc = iv && ir4;
            @(posedge clk); #1;
            if (acc) begin
                sb.push_back(idx);
                idx++;
            end
            cyc++;
        end
        if (idx < first + n) chk("stream_accepted", idx, first + n);
        drain();
    endtask

    // One beat through an empty pipe. The bench checks that ready is up, that nothing appears after one edge,
    // and that the result appears after the second edge.
    task automatic dbeat(input string nm, input logic [1:0] m, input logic [255:0] d,
                         input logic [255:0] e8, input logic [127:0] en);
        iv = 1'b1; im = m; id = d; ordy = 1'b1;
        @(negedge clk);
        chk({nm, " ready"}, {ir4, ir8, irn}, 3'b111);
        @(posedge clk); #1;
        iv = 1'b0; id = '0; im = MIX_RSV;
        @(negedge clk);
        chk({nm, " lat1"}, {ov4, ov8, ovn}, 3'b000);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " lat2"}, {ov4, ov8, ovn}, 3'b111);
        chk({nm, " d8"}, od8, e8);
        chk({nm, " d4"}, {128'b0, od4}, {128'b0, e8[255:128]});
        chk({nm, " dn"}, {128'b0, odn}, {128'b0, en});
        @(posedge clk); #1;
    endtask

    typedef struct {
        string        nm;
        logic [1:0]   mode;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int first;
        int accs;
        int seen;
        bit acc;
        bit seen_inv;
        logic [255:0] x;
        logic [255:0] y;

        tbl[0] = '{"byp",  MIX_BYP, 128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210};
        tbl[1] = '{"fwd1", MIX_FWD, 128'hdb135345_00000000_00000000_00000000, 128'h8e4da1bc_00000000_00000000_00000000};
        tbl[2] = '{"fwd2", MIX_FWD, 128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6, 128'h9fdc589d_d5d5d7d6_4d7ebdf8_c6c6c6c6};
        tbl[3] = '{"fwd3", MIX_FWD, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
        tbl[4] = '{"inv1", MIX_INV, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        tbl[5] = '{"inv2", MIX_INV, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};

        // Reset state.
        iv = 1'b0; im = MIX_FWD; id = '0; ordy = 1'b0; rst_n = 1'b0;
        #12;
        chk("rst_valid", {ov4, ov8, ovn}, 3'b000);
        chk("rst_data", od8 | {od4, odn}, 256'b0);
        chk("rst_err", {err4, err8, errn}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {ir4, ir8, irn}, 3'b111);
        @(posedge clk); #1;

        // Directed table. The 8-column DUT gets the vector plus a column-reversed copy.
        seen_inv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].mode == MIX_INV) seen_inv = 1'b1;
            dbeat(tbl[i].nm, tbl[i].mode,
                  {tbl[i].din, colrev(tbl[i].din)},
                  {tbl[i].dout, colrev(tbl[i].dout)},
                  (tbl[i].mode == MIX_INV) ? tbl[i].din : tbl[i].dout);
            chk({tbl[i].nm, " err"}, {err4, err8, errn}, {2'b00, seen_inv});
        end

        // inv(fwd(x)) == x with the mode alternating on every beat, at full throughput.
        first = nb;
        for (int k = 0; k < 500; k++) begin
            for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom();
            add_beat(MIX_FWD, x);
            y = mstate(x, MIX_FWD, 1'b1);
            add_beat(MIX_INV, y);
            b_e8[nb-1] = x;
        end
        run_stream(first, 1000, 100, 100);

        // Back-pressure: with out_ready low, only two beats fit and the head beat is held.
        first = nb;
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom();
            add_beat(MIX_FWD, x);
        end
        mon_en = 1'b1;
        accs   = 0;
        for (int c = 0; c < 6; c++) begin
            iv = 1'b1; im = b_mode[first + accs]; id = b_data[first + accs]; ordy = 1'b0;
            @(negedge clk);
            acc = iv && ir4;
            if (c >= 2) begin
                chk("bp_ready_low", ir4, 0);
                chk("bp_valid_high", ov4, 1);
                chk("bp_hold", od8, b_e8[first]);
            end
            @(posedge clk); #1;
            if (acc) begin
                sb.push_back(first + accs);
                accs++;
            end
        end
        chk("bp_accepts", accs, 2);
        run_stream(first + accs, 6 - accs, 100, 100);

        // Random valid/ready at 50% each, with mixed modes.
        first = nb;
        for (int k = 0; k < 300; k++) begin
            for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom();
            add_beat(2'($urandom_range(0, 2)), x);
        end
        run_stream(first, 300, 50, 50);

        // Reserved mode 11: output is passed through and err_mode becomes sticky.
        dbeat("rsv", MIX_RSV, {tbl[0].din, tbl[0].din}, {tbl[0].din, tbl[0].din}, tbl[0].din);
        chk("rsv_err", {err4, err8, errn}, 3'b111);
        dbeat("after_rsv", MIX_FWD, {tbl[2].din, colrev(tbl[2].din)},
              {tbl[2].dout, colrev(tbl[2].dout)}, tbl[2].dout);
        chk("rsv_err_sticky", {err4, err8, errn}, 3'b111);

        // Reset with two beats in flight: outputs must clear immediately and nothing stale may come out.
        ordy = 1'b0; iv = 1'b1; im = MIX_FWD; id = {tbl[1].din, tbl[1].din};
        @(posedge clk); #1;
        id = {tbl[2].din, tbl[2].din};
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk);
        chk("mid_full_valid", ov4, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {ov4, ov8, ovn}, 3'b000);
        chk("mid_rst_data", od8 | {od4, odn}, 256'b0);
        chk("mid_rst_err", {err4, err8, errn}, 3'b000);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ordy  = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {ir4, ir8, irn}, 3'b111);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov4 || ov8 || ovn) seen++;
        end
        chk("post_rst_no_stale", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
